// File: rtl/popgen_pkg.sv
// Shared types and constants for the fixed-popcount word generator.
// Optional checker build is selected with POPCOUNT_GEN_CHECK_EN.
package popgen_pkg;

   localparam int POPGEN_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } popgen_state_t;

endpackage

// File: rtl/popcount_w.sv
// Combinational ones count of a W-bit vector.
// Used only when POPCOUNT_GEN_CHECK_EN is defined.
module popcount_w #(
   parameter int W  = 4,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++)
         count = count + CW'(bits[i]);
   end

endmodule

// File: rtl/popcount_word_gen.sv
// Enumerates all W-bit words with exactly k ones in ascending order.
// POPCOUNT_GEN_CHECK_EN adds chk_err and n_words self-check outputs.
module popcount_word_gen
   import popgen_pkg::*;
#(
   parameter int W  = POPGEN_W_DEF,
   parameter int KW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [KW-1:0] k,
   input  logic          ready,
   output logic [W-1:0]  word,
   output logic          valid,
   output logic          last,
   output logic          busy,
   output logic          done,
   output logic          err
`ifdef POPCOUNT_GEN_CHECK_EN
   ,
   output logic          chk_err,
   output logic [15:0]   n_words
`endif
);

   localparam logic [KW-1:0] WK = KW'(W);

   popgen_state_t state;
   logic [KW-1:0] kq;
   logic [W:0]    xe, c, r;
   logic [W-1:0]  succ, pat;

   function automatic int ctz(input logic [W:0] v);
      ctz = 0;
      for (int i = W; i >= 0; i--)
         if (v[i]) ctz = i;
   endfunction

   function automatic logic [W-1:0] ones_mask(input logic [KW-1:0] kk);
      return W'(((W + 1)'(1) << kk) - (W + 1)'(1));
   endfunction

   // Gosper successor at W+1 bits so the add cannot wrap
   always_comb begin
      xe   = {1'b0, word};
      c    = xe & (~xe + (W + 1)'(1));
      r    = xe + c;
      succ = W'((((r ^ xe) >> 2) >> ctz(c)) | r);
      pat  = ones_mask(kq) << (WK - kq);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         kq    <= '0;
         word  <= '0;
         valid <= 1'b0;
         last  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (k > WK) begin
                     err <= 1'b1;
                  end else begin
                     state <= EMIT;
                     kq    <= k;
                     word  <= ones_mask(k);
                     valid <= 1'b1;
                     busy  <= 1'b1;
                     last  <= (k == '0) || (k == WK);
                  end
               end
            end
            EMIT: begin
               if (ready) begin
                  if (last) begin
                     state <= DONE;
                     valid <= 1'b0;
                     last  <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     word <= succ;
                     last <= (succ == pat);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef POPCOUNT_GEN_CHECK_EN
   localparam int CW = $clog2(W + 1);
   logic [CW-1:0] cnt;

   popcount_w #(.W(W), .CW(CW)) u_pop (
      .bits  (word),
      .count (cnt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chk_err <= 1'b0;
         n_words <= '0;
      end else begin
         if (valid && (cnt != CW'(kq)))
            chk_err <= 1'b1;
         if (state == IDLE && start)
            n_words <= '0;
         else if (valid && ready)
            n_words <= n_words + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_popcount_word_gen.sv
// Scoreboard bench for popcount_word_gen (W=4, plus W=8 checker run).
module tb_popcount_word_gen;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n, start, ready;
   logic [2:0]   k;
   logic [W-1:0] word;
   logic         valid, last, busy, done, err;

   int checks = 0;
   int errors = 0;

   logic [W:0] exp_q[$];
   logic [W:0] e;

   always #5 clk = ~clk;

`ifdef POPCOUNT_GEN_CHECK_EN
   logic        chk_err4;
   logic [15:0] n_words4;
`endif

   popcount_word_gen #(.W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .k       (k),
      .ready   (ready),
      .word    (word),
      .valid   (valid),
      .last    (last),
      .busy    (busy),
      .done    (done),
      .err     (err)
`ifdef POPCOUNT_GEN_CHECK_EN
      ,
      .chk_err (chk_err4),
      .n_words (n_words4)
`endif
   );

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // monitor: pop expected {word,last} on every handshake
   always @(negedge clk) begin
      if (valid === 1'b1 && ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got %b expected none", word);
         end else begin
            e = exp_q.pop_front();
            if ({word, last} !== e) begin
               errors++;
               $display("FAIL word_last got %b/%b expected %b/%b",
                        word, last, e[W:1], e[0]);
            end
         end
      end
   end

   task automatic push(input logic [W-1:0] w, input logic l);
      exp_q.push_back({w, l});
   endtask

   task automatic do_start(input logic [2:0] kk);
      start = 1'b1;
      k     = kk;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // counts negedges until done; expected count is words+1
   task automatic wait_done(input string name, input int exp_cyc);
      int cyc = 0;
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) seen = 1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s_timeout got no_done expected done", name);
      end else begin
         chk({name, "_cycles"}, cyc, exp_cyc);
         chk({name, "_done_valid"}, {31'd0, valid}, 0);
         chk({name, "_done_busy"}, {31'd0, busy}, 0);
         @(negedge clk);
         chk({name, "_done_pulse"}, {31'd0, done}, 0);
      end
      @(posedge clk); #1;
   endtask

`ifdef POPCOUNT_GEN_CHECK_EN
   logic        start8;
   logic [3:0]  k8;
   logic [7:0]  word8;
   logic        valid8, last8, busy8, done8, err8, chk_err8;
   logic [15:0] n_words8;
   logic [8:0]  q8[$];
   logic [8:0]  e8;

   popcount_word_gen #(.W(8)) u8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start8),
      .k       (k8),
      .ready   (1'b1),
      .word    (word8),
      .valid   (valid8),
      .last    (last8),
      .busy    (busy8),
      .done    (done8),
      .err     (err8),
      .chk_err (chk_err8),
      .n_words (n_words8)
   );

   always @(negedge clk) begin
      if (valid8 === 1'b1) begin
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("FAIL w8_unexpected got %b expected none", word8);
         end else begin
            e8 = q8.pop_front();
            if ({word8, last8} !== e8) begin
               errors++;
               $display("FAIL w8_word got %b/%b expected %b/%b",
                        word8, last8, e8[8:1], e8[0]);
            end
         end
      end
   end
`endif

   initial begin
      rst_n = 1'b0; start = 1'b0; k = '0; ready = 1'b1;
`ifdef POPCOUNT_GEN_CHECK_EN
      start8 = 1'b0; k8 = '0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {word, valid, last, busy, done, err}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // k=2 full enumeration
      push(4'b0011, 0); push(4'b0101, 0); push(4'b0110, 0);
      push(4'b1001, 0); push(4'b1010, 0); push(4'b1100, 1);
      do_start(3'd2);
      wait_done("k2", 7);
      chk("k2_drain", exp_q.size(), 0);

      // k=0 and k=4 single words
      push(4'b0000, 1);
      do_start(3'd0);
      wait_done("k0", 2);
      push(4'b1111, 1);
      do_start(3'd4);
      wait_done("k4", 2);

      // k=5 rejected
      do_start(3'd5);
      @(negedge clk);
      chk("k5_err", {err, valid, busy}, 3'b100);
      @(negedge clk);
      chk("k5_err_pulse", {err, valid, busy}, 3'b000);
      @(posedge clk); #1;

      // k=1 with backpressure on 0010
      push(4'b0001, 0); push(4'b0010, 0);
      push(4'b0100, 0); push(4'b1000, 1);
      do_start(3'd1);
      @(posedge clk); #1;
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("k1_hold", {word, valid, last}, {4'b0010, 1'b1, 1'b0});
         @(posedge clk); #1;
      end
      ready = 1'b1;
      wait_done("k1", 4);

      // k=3 aborted by reset after 2 handshakes
      push(4'b0111, 0); push(4'b1011, 0);
      do_start(3'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0; ready = 1'b0;
      @(posedge clk); #1;
      chk("abort_outs", {word, valid, busy, done}, 0);
      rst_n = 1'b1; ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, done}, 0);
      end
      @(posedge clk); #1;
      chk("abort_drain", exp_q.size(), 0);
      push(4'b0001, 0); push(4'b0010, 0);
      push(4'b0100, 0); push(4'b1000, 1);
      do_start(3'd1);
      wait_done("restart_k1", 5);
      chk("final_drain", exp_q.size(), 0);

`ifdef POPCOUNT_GEN_CHECK_EN
      chk("w4_chk_err", {31'd0, chk_err4}, 0);
      for (int x = 0; x < 256; x++) begin
         logic [7:0] xb;
         xb = x[7:0];
         if ($countones(xb) == 3) q8.push_back({xb, xb == 8'hE0});
      end
      chk("w8_expect_count", q8.size(), 56);
      start8 = 1'b1; k8 = 4'd3;
      @(posedge clk); #1;
      start8 = 1'b0;
      begin
         bit seen = 0;
         for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) seen = 1;
         end
         chk("w8_done_seen", {31'd0, seen}, 1);
      end
      chk("w8_chk_err", {31'd0, chk_err8}, 0);
      chk("w8_n_words", {16'd0, n_words8}, 56);
      chk("w8_drain", q8.size(), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/popcount_word_gen.md
POPCOUNT_WORD_GEN -- requirements
Module: popcount_word_gen

Interface
REQ-001 Parameter W, default 4: generated word width; legal range 2..16.
REQ-002 Parameter KW, default $clog2(W+1): width of the requested ones count.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a new enumeration; sampled only in IDLE.
REQ-006 k  input  KW  requested number of ones per word; sampled with start.
REQ-007 ready  input  1  consumer accepts the current word when ready and valid are both high.
REQ-008 word  output  W  generated word; every emitted word has exactly k ones.
REQ-009 valid  output  1  word is valid.
REQ-010 last  output  1  qualifies the final word of the enumeration; meaningful only with valid.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse after the last handshake.
REQ-013 err  output  1  one-cycle pulse when start is accepted with k > W.

Function
REQ-014 FSM states: IDLE, EMIT, DONE. Encoding: 2-bit enum.
REQ-015 IDLE, start=1, k<=W -> EMIT. word=(1<<k)-1 and valid=1 in the next cycle, giving 1-cycle latency.
REQ-016 IDLE, start=1, k>W -> stay IDLE. err=1 for exactly the next cycle; no valid is emitted.
REQ-017 EMIT: words appear in strictly ascending numeric order, covering all C(W,k) patterns exactly once.
REQ-018 The successor of word x is computed by Gosper's rule: c=x&-x, r=x+c, next=(((r^x)>>2)>>ctz(c))|r. The shift replaces the division, so no divider is used.
REQ-019 last=1 exactly when word equals ((1<<k)-1)<<(W-k).
REQ-020 k=0: a single word 0 is emitted with last=1. k=W: a single word of all ones is emitted with last=1.
REQ-021 While valid=1 and ready=0, word and last hold stable and valid stays high.
REQ-022 A handshake on a non-last word presents the successor word in the next cycle with no bubble. Full throughput is 1 word per cycle.
REQ-023 A handshake on the last word -> DONE. In that next cycle valid=0, busy=0, done=1. Then -> IDLE.
REQ-024 start is ignored in EMIT and DONE. A start in the DONE cycle is not queued.
REQ-025 Intermediate arithmetic is carried out at W+1 bits so that r cannot wrap; word carries only the low W bits.

Reset
REQ-026 When rst_n=0 at a posedge: state=IDLE; word=0; valid, last, busy, done, err=0.
REQ-027 Reset asserted mid-enumeration abandons the enumeration without emitting done. Outputs take their reset values in the cycle after the sampled reset.

Configuration
REQ-028 Macro POPCOUNT_GEN_CHECK_EN.
- When defined: an extra output chk_err (1 bit, sticky, cleared by reset) is set if any word with valid=1 has popcount != k. An extra output n_words (16 bits) counts handshakes since the last accepted start.
- When undefined: chk_err and n_words and their logic are absent. Generation behaviour is unchanged.

Structure
REQ-029 Package popgen_pkg holds the state enum type popgen_state_t and the default width constant POPGEN_W_DEF=4.
REQ-030 Sub-module popcount_w (parameter W): combinational ones count of a W-bit input. It is instantiated only under POPCOUNT_GEN_CHECK_EN. ctz is a local function.

Verification
REQ-031 The bench SHALL cover the following directed scenarios, with W=4 unless noted:
- k=2, ready=1 held -> words 0011, 0101, 0110, 1001, 1010, 1100 on consecutive cycles; last only on 1100; done on the following cycle.
- k=0 -> one word 0000 with last=1, then done. Separately, k=4 -> one word 1111 with last=1.
- k=5 -> err pulse 1 cycle after start; valid stays 0; busy stays 0.
- k=1, ready=0 for 3 cycles while 0010 is presented -> 0010 held stable; then 0100 and 1000 follow.
- k=3, rst_n=0 after 2 handshakes -> valid=0 and busy=0 next cycle; no done; a new start k=1 then begins at 0001.
- With POPCOUNT_GEN_CHECK_EN, W=8, k=3, ready=1 -> 56 words, chk_err=0, n_words=56.
